cp0_ctrl: RTL and testbench

CP0_CTRL -- requirements
Module: cp0_ctrl

---
 rtl/cp0_ctrl.sv | 127 ++++++++++++
 tb/tb_cp0_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_ctrl
//  Description : MIPS-style coprocessor 0. Holds SR, Cause, EPC and PRId,
//                raises the exception/interrupt redirect request for the M
//                stage and serves mfc0 reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        we,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        req,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    localparam logic [4:0]  C_REG_SR    = 5'd12;
    localparam logic [4:0]  C_REG_CAUSE = 5'd13;
    localparam logic [4:0]  C_REG_EPC   = 5'd14;
    localparam logic [4:0]  C_REG_PRID  = 5'd15;
    localparam logic [31:0] C_PRID_VAL  = 32'h4D44_0007;

    // SR fields
    logic [5:0]  im_q,  im_d;
    logic        exl_q, exl_d;
    logic        ie_q,  ie_d;
    // Cause fields
    logic        bd_q,  bd_d;
    logic [5:0]  ip_q,  ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    // EPC
    logic [31:0] epc_q, epc_d;

    logic        w_int_req;
    logic        w_exc_req;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic [31:0] w_epc_target;

    assign w_int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign w_exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
    assign req       = w_int_req | w_exc_req;

    // A delay-slot instruction restarts at its branch so it is re-executed.
    assign w_epc_target = BDIn ? (PC - 32'd4) : PC;

    assign w_sr    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign w_cause = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = HWInt;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        if (req) begin
            // Taking the trap discards any mtc0 and any eret in the same cycle.
            exl_d      = 1'b1;
            bd_d       = BDIn;
            exc_code_d = w_int_req ? 5'd0 : ExcCodeIn;
            epc_d      = w_epc_target;
        end else begin
            if (we) begin
                case (A2)
                    C_REG_SR: begin
                        im_d  = DIn[15:10];
                        exl_d = DIn[1];
                        ie_d  = DIn[0];
                    end
                    C_REG_EPC: epc_d = DIn;
                    default:   ;
                endcase
            end
            // eret overrides an SR write for EXL only.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        DOut = 32'd0;
        case (A1)
            C_REG_SR:    DOut = w_sr;
            C_REG_CAUSE: DOut = w_cause;
            C_REG_EPC:   DOut = epc_q;
            C_REG_PRID:  DOut = C_PRID_VAL;
            default:     DOut = 32'd0;
        endcase
    end

    assign EPCOut = epc_q;

endmodule
`default_nettype wire

// File: tb/tb_cp0_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_ctrl
//  Description : Self-checking scoreboard bench for cp0_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        we;
    logic [31:0] PC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        req;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    int n_checks = 0;
    int n_errors = 0;

    string       sb_tag[$];
    logic [31:0] sb_exp[$];

    cp0_ctrl u_dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .we        (we),
        .PC        (PC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .req       (req),
        .EPCOut    (EPCOut),
        .DOut      (DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_tag.push_back(tag);
        sb_exp.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (sb_exp.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            check(sb_tag.pop_front(), obs, sb_exp.pop_front());
        end
    endtask

    task automatic chk_rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        sb_push(tag, exp);
        A1 = a;
        #1;
        sb_pop(DOut);
    endtask

    task automatic chk_req(input string tag, input logic exp);
        sb_push(tag, {31'd0, exp});
        #1;
        sb_pop({31'd0, req});
    endtask

    task automatic chk_epc(input string tag, input logic [31:0] exp);
        sb_push(tag, exp);
        #1;
        sb_pop(EPCOut);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we        = 1'b0;
        A2        = 5'd0;
        DIn       = 32'd0;
        PC        = 32'd0;
        BDIn      = 1'b0;
        ExcCodeIn = 5'd0;
        HWInt     = 6'd0;
        EXLClr    = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        we  = 1'b1;
        A2  = a;
        DIn = d;
        tick();
        idle();
    endtask

    task automatic eret();
        idle();
        EXLClr = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        logic [31:0] rnd;
        A1    = 5'd0;
        reset = 1'b0;
        idle();
        #2;
        // Reset state, req only follows ExcCodeIn while reset
        chk_rd("rst_sr", 5'd12, 32'd0);
        chk_rd("rst_cause", 5'd13, 32'd0);
        chk_rd("rst_epc", 5'd14, 32'd0);
        chk_epc("rst_epcout", 32'd0);
        chk_req("rst_req0", 1'b0);
        tick();
        reset = 1'b1;
        tick();

        HWInt = 6'h3f;
        chk_req("ie0_masks_int", 1'b0);
        ExcCodeIn = 5'd5;
        chk_req("post_rst_exc_req", 1'b1);
        idle();

        // Plain exception
        ExcCodeIn = 5'd12;
        PC        = 32'h3010;
        chk_req("exc_req", 1'b1);
        tick();
        chk_req("exc_no_nest", 1'b0);
        idle();
        chk_epc("exc_epcout", 32'h3010);
        chk_rd("exc_epc", 5'd14, 32'h3010);
        chk_rd("exc_cause", 5'd13, 32'h0000_0030);
        chk_rd("exc_sr", 5'd12, 32'h0000_0002);
        eret();
        chk_rd("eret_sr", 5'd12, 32'h0);

        // Interrupt in a delay slot
        mtc0(5'd12, 32'h0000_0401);
        chk_rd("mtc0_sr", 5'd12, 32'h0000_0401);
        HWInt = 6'b000001;
        PC    = 32'h3024;
        BDIn  = 1'b1;
        chk_req("int_req", 1'b1);
        tick();
        idle();
        chk_rd("int_epc", 5'd14, 32'h3020);
        chk_rd("int_cause", 5'd13, 32'h8000_0400);
        chk_rd("int_sr", 5'd12, 32'h0000_0403);
        eret();
        chk_rd("ip_resample", 5'd13, 32'h8000_0000);
        chk_rd("eret2_sr", 5'd12, 32'h0000_0401);

        // Interrupt beats exception
        HWInt     = 6'b000001;
        ExcCodeIn = 5'd4;
        PC        = 32'h3100;
        chk_req("int_exc_req", 1'b1);
        tick();
        chk_req("nest_blocked", 1'b0);
        ExcCodeIn = 5'd8;
        chk_req("nest_blocked_exc8", 1'b0);
        idle();
        chk_rd("prio_cause", 5'd13, 32'h0000_0400);
        chk_rd("prio_epc", 5'd14, 32'h3100);
        eret();

        // mtc0 EPC collides with an exception
        we        = 1'b1;
        A2        = 5'd14;
        DIn       = 32'h5000;
        ExcCodeIn = 5'd10;
        PC        = 32'h3400;
        chk_req("coll_req", 1'b1);
        tick();
        idle();
        chk_rd("coll_epc", 5'd14, 32'h3400);
        chk_rd("coll_cause", 5'd13, 32'h0000_0028);
        eret();

        // eret loses to a simultaneous trap
        EXLClr    = 1'b1;
        ExcCodeIn = 5'd3;
        PC        = 32'h3500;
        chk_req("eret_trap_req", 1'b1);
        tick();
        idle();
        chk_rd("eret_trap_sr", 5'd12, 32'h0000_0403);
        chk_rd("eret_trap_cause", 5'd13, 32'h0000_000C);
        chk_rd("eret_trap_epc", 5'd14, 32'h3500);

        // eret and SR write together: EXL cleared, IM/IE written
        we     = 1'b1;
        A2     = 5'd12;
        DIn    = 32'h0000_FC03;
        EXLClr = 1'b1;
        tick();
        idle();
        chk_rd("eret_sr_wr", 5'd12, 32'h0000_FC01);

        // Writes to Cause/PRId ignored, no write-to-read bypass on EPC
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk_rd("cause_ro", 5'd13, 32'h0000_000C);
        mtc0(5'd15, 32'h0);
        chk_rd("prid_ro", 5'd15, 32'h4D44_0007);
        we  = 1'b1;
        A2  = 5'd14;
        DIn = 32'h1234_5678;
        chk_rd("no_bypass", 5'd14, 32'h3500);
        chk_epc("no_bypass_out", 32'h3500);
        tick();
        idle();
        chk_epc("epc_wr", 32'h1234_5678);

        // PC-4 wraps
        ExcCodeIn = 5'd1;
        BDIn      = 1'b1;
        PC        = 32'h0;
        tick();
        idle();
        chk_rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        chk_rd("wrap_cause", 5'd13, 32'h8000_0004);
        chk_rd("wrap_sr", 5'd12, 32'h0000_FC03);
        chk_rd("rd_a9", 5'd9, 32'h0);
        chk_rd("rd_a31", 5'd31, 32'h0);
        chk_rd("rd_a0", 5'd0, 32'h0);

        // Random mtc0 round trips with no trap pending
        for (int i = 0; i < 8; i++) begin
            rnd = $urandom;
            mtc0(5'd14, rnd);
            chk_rd("rnd_epc", 5'd14, rnd);
            rnd = $urandom;
            mtc0(5'd12, rnd);
            chk_rd("rnd_sr", 5'd12, rnd & 32'h0000_FC03);
        end

        // Asynchronous reset mid-cycle while EXL=1
        mtc0(5'd12, 32'h0);
        ExcCodeIn = 5'd12;
        PC        = 32'h3010;
        tick();
        idle();
        chk_rd("pre_arst_epc", 5'd14, 32'h3010);
        reset = 1'b0;
        chk_rd("arst_sr", 5'd12, 32'h0);
        chk_rd("arst_cause", 5'd13, 32'h0);
        chk_rd("arst_epc", 5'd14, 32'h0);

        // Reset held across a cycle with req=1
        ExcCodeIn = 5'd7;
        PC        = 32'h3600;
        chk_req("rst_trap_req", 1'b1);
        tick();
        idle();
        chk_rd("rst_trap_sr", 5'd12, 32'h0);
        chk_rd("rst_trap_epc", 5'd14, 32'h0);

        // Release takes effect at the next edge
        reset = 1'b1;
        we    = 1'b1;
        A2    = 5'd14;
        DIn   = 32'h0000_0ABC;
        chk_rd("rel_before", 5'd14, 32'h0);
        tick();
        idle();
        chk_rd("rel_after", 5'd14, 32'h0000_0ABC);

        check("sb_drained", sb_exp.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
